banco_escritura_arbitro: RTL and testbench

Write-port controller for the 32×32 register file (`Banco_Registros`). It owns the single write port (`A3`/`WD3`/`WE3`) and sequences it in two phases. After reset it zero-fills every register. It then shares the port between two writeback requesters (0 = ALU writeback, 1 = memory-load writeback) using round-robin arbitration with a request/grant handshake. The read ports (`A1`/`A2`/`RD1`/`RD2`) are not touched by this block.

---
 rtl/banco_escritura_arbitro.sv | 128 ++++++++++++
 tb/tb_banco_escritura_arbitro.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_escritura_arbitro.sv
// Write-port controller for the 32x32 register file: zero-fills every register after
// reset, then round-robin arbitrates the write port between ALU and load writeback.
module banco_escritura_arbitro #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              WE3,
    output logic              init_done
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              we3_q, we3_d;
    logic              init_q, init_d;

    logic              elig0_s;
    logic              elig1_s;
    logic              win1_s;

    // A requester granted last cycle sits out one cycle; on a tie the one not served last wins.
    assign elig0_s = req0 & ~gnt0_q;
    assign elig1_s = req1 & ~gnt1_q;
    assign win1_s  = elig1_s & (~elig0_s | ~last_q);

    // Next-state logic for the clear sequencer and the arbiter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        a3_d    = a3_q;
        wd3_d   = wd3_q;
        we3_d   = 1'b0;
        init_d  = init_q;
        case (state_q)
            ST_CLEAR: begin
                we3_d = 1'b1;
                a3_d  = ptr_q;
                wd3_d = {DATA_W{1'b0}};
                ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                    init_d  = 1'b1;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (elig0_s || elig1_s) begin
                    if (win1_s) begin
                        gnt1_d = 1'b1;
                        a3_d   = addr1;
                        wd3_d  = data1;
                        last_d = 1'b1;
                        we3_d  = (addr1 != {ADDR_W{1'b0}});
                    end else begin
                        gnt0_d = 1'b1;
                        a3_d   = addr0;
                        wd3_d  = data0;
                        last_d = 1'b0;
                        we3_d  = (addr0 != {ADDR_W{1'b0}});
                    end
                end else begin
                    we3_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = {ADDR_W{1'b0}};
                init_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; register 0 writes are granted but never enabled.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= {ADDR_W{1'b0}};
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            a3_q    <= {ADDR_W{1'b0}};
            wd3_q   <= {DATA_W{1'b0}};
            we3_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            a3_q    <= a3_d;
            wd3_q   <= wd3_d;
            we3_q   <= we3_d;
            init_q  <= init_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;
    assign WE3       = we3_q;
    assign init_done = init_q;

endmodule

// File: tb/tb_banco_escritura_arbitro.sv
// Self-checking bench: a behavioural write-port model plus a stand-in register file.
module tb_banco_escritura_arbitro;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [4:0]  addr0 = 5'd0, addr1 = 5'd0;
    logic [31:0] data0 = 32'd0, data1 = 32'd0;
    logic        gnt0, gnt1, WE3, init_done;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int checks = 0;
    int errors = 0;

    // expected outputs and model state
    logic        e_gnt0, e_gnt1, e_we, e_init;
    logic [4:0]  e_a;
    logic [31:0] e_wd;
    int          m_cnt;
    int          m_last;
    logic [31:0] ref_mem [32];

    // stand-in register file fed by the DUT write port
    logic [31:0] rf [32];
    logic        rf_seed = 1'b0;

    banco_escritura_arbitro #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK(CLK), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .A3(A3), .WD3(WD3), .WE3(WE3), .init_done(init_done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (rf_seed) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'hA5A5_0000 + 32'(i);
        end else if (WE3) begin
            rf[A3] <= WD3;
        end
    end

    task automatic model_reset();
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_we = 1'b0; e_init = 1'b0;
        e_a = 5'd0; e_wd = 32'd0;
        m_cnt = 0;
        m_last = 1;
    endtask

    // One rising edge of the reference: clear 32 registers, then round-robin writes.
    task automatic model_edge();
        bit el0, el1;
        int w;
        if (e_we) ref_mem[e_a] = e_wd;
        if (m_cnt < 32) begin
            e_we = 1'b1; e_a = 5'(m_cnt); e_wd = 32'd0;
            e_gnt0 = 1'b0; e_gnt1 = 1'b0;
            m_cnt++;
            if (m_cnt == 32) e_init = 1'b1;
        end else begin
            el0 = req0 && !e_gnt0;
            el1 = req1 && !e_gnt1;
            e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_we = 1'b0;
            if (el0 || el1) begin
                if (el0 && el1) w = 1 - m_last;
                else w = el1 ? 1 : 0;
                m_last = w;
                if (w == 0) begin
                    e_gnt0 = 1'b1; e_a = addr0; e_wd = data0;
                end else begin
                    e_gnt1 = 1'b1; e_a = addr1; e_wd = data1;
                end
                e_we = (e_a != 5'd0);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!reset) model_edge();
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rf_seed = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        rf_seed = 1'b0;
        apply_reset();
        checks++;
        if ({gnt0, gnt1, WE3, A3, WD3, init_done} !== 40'd0) begin
            errors++;
            $display("FAIL reset_values: got %h want 0", {gnt0, gnt1, WE3, A3, WD3, init_done});
        end
        release_reset();
    endtask

    task automatic test_zero_fill();
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (WE3 !== 1'b1 || A3 !== 5'(k - 1) || WD3 !== 32'd0 || init_done !== (k == 32) ||
                gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL zero_fill edge %0d: got we=%b a3=%0d wd=%h init=%b want we=1 a3=%0d wd=0 init=%b",
                         k, WE3, A3, WD3, init_done, k - 1, k == 32);
            end
        end
        tick();
        tick();
        checks++;
        if (rf[10] !== 32'd0 || rf[5] !== 32'd0 || rf[31] !== 32'd0) begin
            errors++;
            $display("FAIL zero_fill_read: got rd10=%h rd5=%h rd31=%h want 0", rf[10], rf[5], rf[31]);
        end
    endtask

    task automatic test_contention();
        req0 = 1'b1; addr0 = 5'd5; data0 = 32'h12F;
        req1 = 1'b1; addr1 = 5'd7; data1 = 32'hABC;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1) ||
                {WE3, A3, WD3} !== {e_we, e_a, e_wd}) begin
                errors++;
                $display("FAIL contention cyc %0d: got g0=%b g1=%b a3=%0d wd=%h want g0=%b g1=%b a3=%0d wd=%h",
                         i, gnt0, gnt1, A3, WD3, i % 2 == 0, i % 2 == 1, e_a, e_wd);
            end
        end
        req1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (gnt0 !== (i % 2 == 0) || gnt1 !== 1'b0 || WE3 !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL lone_req0 cyc %0d: got g0=%b g1=%b we=%b want g0=%b g1=0",
                         i, gnt0, gnt1, WE3, i % 2 == 0);
            end
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0 = 1'b1; addr0 = 5'd10; data0 = 32'hFF;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || A3 !== 5'd10 || WD3 !== 32'hFF || WE3 !== 1'b1) begin
            errors++;
            $display("FAIL single_req: got g0=%b a3=%0d wd=%h we=%b want g0=1 a3=10 wd=ff we=1",
                     gnt0, A3, WD3, WE3);
        end
        req0 = 1'b0;
        tick();
        tick();
        checks++;
        if (rf[10] !== 32'hFF) begin
            errors++;
            $display("FAIL single_read: got rd10=%h want ff", rf[10]);
        end
    endtask

    task automatic test_reg0();
        req1 = 1'b1; addr1 = 5'd0; data1 = 32'hDEAD;
        tick();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || WE3 !== 1'b0) begin
            errors++;
            $display("FAIL reg0_grant: got g1=%b g0=%b we=%b want g1=1 g0=0 we=0", gnt1, gnt0, WE3);
        end
        req1 = 1'b0;
        tick();
        tick();
        checks++;
        if (rf[0] !== 32'd0) begin
            errors++;
            $display("FAIL reg0_read: got rd0=%h want 0", rf[0]);
        end
    endtask

    task automatic test_clear_requests();
        apply_reset();
        req0 = 1'b1; addr0 = 5'd3; data0 = 32'h77;
        release_reset();
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (gnt0 !== 1'b0 || A3 !== 5'(k - 1)) begin
                errors++;
                $display("FAIL clear_ignores_req edge %0d: got g0=%b a3=%0d want g0=0 a3=%0d",
                         k, gnt0, A3, k - 1);
            end
        end
        tick();
        checks++;
        if (gnt0 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'h77 || WE3 !== 1'b1) begin
            errors++;
            $display("FAIL first_grant_edge33: got g0=%b a3=%0d wd=%h we=%b want g0=1 a3=3 wd=77 we=1",
                     gnt0, A3, WD3, WE3);
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        release_reset();
        for (int k = 1; k <= 13; k++) tick();
        checks++;
        if (A3 !== 5'd12 || WE3 !== 1'b1) begin
            errors++;
            $display("FAIL pre_mid_reset: got a3=%0d we=%b want a3=12 we=1", A3, WE3);
        end
        apply_reset();
        checks++;
        if ({gnt0, gnt1, WE3, A3, WD3, init_done} !== 40'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %h want 0", {gnt0, gnt1, WE3, A3, WD3, init_done});
        end
        release_reset();
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (A3 !== 5'(k - 1) || WE3 !== 1'b1 || init_done !== (k == 32)) begin
                errors++;
                $display("FAIL reclear edge %0d: got a3=%0d we=%b init=%b want a3=%0d we=1 init=%b",
                         k, A3, WE3, init_done, k - 1, k == 32);
            end
        end
        req1 = 1'b1; addr1 = 5'd9; data1 = 32'h55;
        tick();
        checks++;
        if (gnt1 !== 1'b1 || A3 !== 5'd9) begin
            errors++;
            $display("FAIL grant_before_reset: got g1=%b a3=%0d want g1=1 a3=9", gnt1, A3);
        end
        apply_reset();
        checks++;
        if ({gnt0, gnt1, WE3, A3, WD3, init_done} !== 40'd0) begin
            errors++;
            $display("FAIL reset_mid_grant: got %h want 0", {gnt0, gnt1, WE3, A3, WD3, init_done});
        end
        release_reset();
        for (int k = 1; k <= 32; k++) tick();
        tick();
        checks++;
        if (gnt1 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'h55 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL served_after_reclear: got g1=%b a3=%0d wd=%h init=%b want g1=1 a3=9 wd=55 init=1",
                     gnt1, A3, WD3, init_done);
        end
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!req0 || e_gnt0) begin
                if ($urandom_range(0, 3) != 0) begin
                    req0 = 1'b1; addr0 = 5'($urandom_range(0, 31)); data0 = $urandom;
                end else begin
                    req0 = 1'b0;
                end
            end
            if (!req1 || e_gnt1) begin
                if ($urandom_range(0, 2) != 0) begin
                    req1 = 1'b1; addr1 = 5'($urandom_range(0, 31)); data1 = $urandom;
                end else begin
                    req1 = 1'b0;
                end
            end
            tick();
            checks++;
            if ({gnt0, gnt1, WE3, A3, WD3, init_done} !== {e_gnt0, e_gnt1, e_we, e_a, e_wd, e_init}) begin
                errors++;
                $display("FAIL random cyc %0d: got g0=%b g1=%b we=%b a3=%0d wd=%h init=%b want g0=%b g1=%b we=%b a3=%0d wd=%h init=%b",
                         c, gnt0, gnt1, WE3, A3, WD3, init_done, e_gnt0, e_gnt1, e_we, e_a, e_wd, e_init);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (rf[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL random_regfile r%0d: got %h want %h", i, rf[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
        model_reset();
        test_reset();
        test_zero_fill();
        test_contention();
        test_single();
        test_reg0();
        test_clear_requests();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
